uart_receiver: RTL

8N1 UART receiver, the receive-side counterpart of the UART transmit path. Synchronises the asynchronous `rx` line, detects the start bit, and samples each bit at mid-bit using an internal baud counter. It delivers bytes over a valid/ready handshake to the consuming logic (stack-machine I/O or FIFO). Framing errors and overruns are reported as single-cycle pulses.

---
 rtl/uart_pkg.sv | 23 ++
 rtl/baud_tick.sv | 37 +++
 rtl/uart_receiver.sv | 123 ++++++++++++
 3 files changed

// File: rtl/uart_pkg.sv
// -----------------------------------------------------------------------------
// uart_pkg : shared UART types and defaults for the receive and transmit paths
// Rev 1.0
// -----------------------------------------------------------------------------
`default_nettype none

package uart_pkg;

   localparam int DataBits = 8;

   // 50 MHz system clock at 115200 baud
   localparam int ClocksPerBitDefault = 434;

   typedef enum logic [1:0] {
      RX_IDLE  = 2'd0,
      RX_START = 2'd1,
      RX_DATA  = 2'd2,
      RX_STOP  = 2'd3
   } uart_rx_state_t;

endpackage

`default_nettype wire

// File: rtl/baud_tick.sv
// -----------------------------------------------------------------------------
// baud_tick : free-running bit-period counter with a mid-period sample strobe
// Rev 1.0
// -----------------------------------------------------------------------------
`default_nettype none

module baud_tick #(
   parameter int Period = 16,
   parameter int TickAt = Period >> 1
) (
   input  logic clk,
   input  logic rst_n,
   input  logic clear,
   output logic tick
);

   localparam int CW = $clog2(Period);
   localparam logic [CW-1:0] LastCount = CW'(Period - 1);
   localparam logic [CW-1:0] TickCount = CW'(TickAt);

   logic [CW-1:0] count_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         count_q <= '0;
      end else if (clear || (count_q == LastCount)) begin
         count_q <= '0;
      end else begin
         count_q <= count_q + CW'(1);
      end
   end

   assign tick = (count_q == TickCount);

endmodule

`default_nettype wire

// File: rtl/uart_receiver.sv
// -----------------------------------------------------------------------------
// uart_receiver : 8N1 UART receiver with valid/ready byte output
// Rev 1.0
// -----------------------------------------------------------------------------
`default_nettype none

module uart_receiver
   import uart_pkg::*;
#(
   parameter int ClocksPerBit = ClocksPerBitDefault,
   parameter int HalfBit      = ClocksPerBit >> 1
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic                rx,
   output logic [DataBits-1:0] data,
   output logic                valid,
   input  logic                ready,
   output logic                frame_error,
   output logic                overrun
);

   localparam int IdxW = $clog2(DataBits);
   localparam logic [IdxW-1:0] LastBit = IdxW'(DataBits - 1);

   uart_rx_state_t      state_q;
   logic [1:0]          sync_q;
   logic [IdxW-1:0]     bit_idx_q;
   logic [DataBits-1:0] shift_q;
   logic [DataBits-1:0] data_q;
   logic                valid_q;
   logic                frame_error_q;
   logic                overrun_q;

   logic                rx_s;
   logic                tick;
   logic                clear;

   assign rx_s  = sync_q[1];
   assign clear = (state_q == RX_IDLE);

   baud_tick #(
      .Period (ClocksPerBit),
      .TickAt (HalfBit)
   ) u_baud_tick (
      .clk   (clk),
      .rst_n (rst_n),
      .clear (clear),
      .tick  (tick)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sync_q        <= 2'b11;
         state_q       <= RX_IDLE;
         bit_idx_q     <= '0;
         shift_q       <= '0;
         data_q        <= '0;
         valid_q       <= 1'b0;
         frame_error_q <= 1'b0;
         overrun_q     <= 1'b0;
      end else begin
         sync_q        <= {sync_q[0], rx};
         frame_error_q <= 1'b0;
         overrun_q     <= 1'b0;

         // A new byte loading in the stop branch below overrides this drop
         if (valid_q && ready) begin
            valid_q <= 1'b0;
         end

         case (state_q)
            RX_IDLE: begin
               if (!rx_s) begin
                  state_q <= RX_START;
               end
            end
            RX_START: begin
               if (tick) begin
                  if (rx_s) begin
                     state_q <= RX_IDLE;
                  end else begin
                     state_q   <= RX_DATA;
                     bit_idx_q <= '0;
                  end
               end
            end
            RX_DATA: begin
               if (tick) begin
                  shift_q <= {rx_s, shift_q[DataBits-1:1]};
                  if (bit_idx_q == LastBit) begin
                     state_q <= RX_STOP;
                  end else begin
                     bit_idx_q <= bit_idx_q + IdxW'(1);
                  end
               end
            end
            RX_STOP: begin
               if (tick) begin
                  state_q <= RX_IDLE;
                  if (!rx_s) begin
                     frame_error_q <= 1'b1;
                  end else if (valid_q && !ready) begin
                     overrun_q <= 1'b1;
                  end else begin
                     data_q  <= shift_q;
                     valid_q <= 1'b1;
                  end
               end
            end
            default: state_q <= RX_IDLE;
         endcase
      end
   end

   assign data        = data_q;
   assign valid       = valid_q;
   assign frame_error = frame_error_q;
   assign overrun     = overrun_q;

endmodule

`default_nettype wire
